// File: rtl/ffd_arb_pkg.sv
// ffd_arb_pkg: shared types and default sizes for the FFD write arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WRITE, CHECK)
//   DEF_NREQ    : default requester count
//   DEF_DW      : default shared register width
//   IDXW        : requester index width for the default requester count
package ffd_arb_pkg;
  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 4;
  localparam int IDXW     = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req    in  NREQ  request vector
//   rr_ptr in  IW    index holding first priority
//   valid  out 1     any request present
//   winner out IW    first requester at or after rr_ptr, wrapping modulo NREQ
module rr_pick
  import ffd_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = IDXW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   winner
);
  // Scan from the farthest offset back to rr_ptr so the closest request wins.
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) winner = IW'((int'(rr_ptr) + k) % NREQ);
    end
  end
endmodule

// File: rtl/ffd_write_arbiter.sv
// ffd_write_arbiter: round-robin arbiter sharing one enable-gated register
// bank among NREQ requesters. Each write: grant + one-cycle enable (WRITE),
// readback cycle (CHECK), then a one-cycle ack.
//   clk    in  1        rising-edge clock
//   reset  in  1        asynchronous active-low reset
//   req    in  NREQ     level write requests
//   wdata  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
//   gnt    out NREQ     registered one-hot grant
//   ack    out NREQ     one-cycle completion pulse
//   err    out 1        pulses with ack when readback retries are exhausted
//   busy   out 1        FSM not IDLE
//   ff_en  out 1        bank enable
//   ff_d   out DW       bank data, registered
//   ff_q   in  DW       bank readback
// Optional: define FFD_ARB_READBACK_CHECK_EN to compare ff_q against ff_d in
// CHECK and rewrite up to MAX_RETRY times before flagging err.
module ffd_write_arbiter
  import ffd_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic              ff_en,
  output logic [DW-1:0]     ff_d,
  input  logic [DW-1:0]     ff_q
);
  localparam int IW = $clog2(NREQ);

  arb_state_t      state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n, win, win_n, pick;
  logic            pick_vld, done;
  logic [NREQ-1:0] gnt_n, ack_n;
  logic            ff_en_n;
  logic [DW-1:0]   ff_d_n;

`ifdef FFD_ARB_READBACK_CHECK_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt, retry_n;
  logic          err_q, err_n;
  assign err = err_q;
`else
  localparam int unused_max_retry = MAX_RETRY;
  logic unused_q;
  assign unused_q = ^ff_q;
  assign err      = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .winner (pick)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    ack_n    = '0;
    ff_en_n  = ff_en;
    ff_d_n   = ff_d;
    rr_ptr_n = rr_ptr;
    win_n    = win;
    done     = 1'b0;
`ifdef FFD_ARB_READBACK_CHECK_EN
    retry_n  = retry_cnt;
    err_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          ff_d_n      = wdata[pick*DW +: DW];
          ff_en_n     = 1'b1;
          win_n       = pick;
          state_n     = WRITE;
        end
      end
      WRITE: begin
        ff_en_n = 1'b0;
        state_n = CHECK;
      end
      CHECK: begin
`ifdef FFD_ARB_READBACK_CHECK_EN
        // ff_d still holds the value written, so a rewrite just re-enables.
        if ((ff_q != ff_d) && (retry_cnt < RW'(MAX_RETRY))) begin
          retry_n = retry_cnt + RW'(1);
          ff_en_n = 1'b1;
          state_n = WRITE;
        end else begin
          done  = 1'b1;
          err_n = (ff_q != ff_d);
        end
`else
        done = 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase

    // Pointer moves only on completion, so a grant alone never rotates priority.
    if (done) begin
      ack_n[win] = 1'b1;
      gnt_n      = '0;
      rr_ptr_n   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
      state_n    = IDLE;
`ifdef FFD_ARB_READBACK_CHECK_EN
      retry_n    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      gnt    <= '0;
      ack    <= '0;
      ff_en  <= 1'b0;
      ff_d   <= '0;
      rr_ptr <= '0;
      win    <= '0;
`ifdef FFD_ARB_READBACK_CHECK_EN
      retry_cnt <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      ff_en  <= ff_en_n;
      ff_d   <= ff_d_n;
      rr_ptr <= rr_ptr_n;
      win    <= win_n;
`ifdef FFD_ARB_READBACK_CHECK_EN
      retry_cnt <= retry_n;
      err_q     <= err_n;
`endif
    end
  end
endmodule

// File: tb/tb_ffd_write_arbiter.sv
// Bench for ffd_write_arbiter: directed cycle table, hand sequences for
// multi-cycle corners, and a randomized run against a transaction timeline model.
module tb_ffd_write_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt, ack;
  logic           err, busy, ff_en;
  logic [W-1:0]   ff_d, ff_q, bank_q;
  logic           force_q0;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  ffd_write_arbiter #(.NREQ(N), .DW(W), .MAX_RETRY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .err   (err),
    .busy  (busy),
    .ff_en (ff_en),
    .ff_d  (ff_d),
    .ff_q  (ff_q)
  );

  // Shared register bank; force_q0 models a stuck readback.
  always @(posedge clk or negedge reset) begin
    if (!reset) bank_q <= '0;
    else if (ff_en) bank_q <= ff_d;
  end
  assign ff_q = force_q0 ? '0 : bank_q;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] wd;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        en;
    logic [3:0]  d;
    logic        busy;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [14:0] obs();
    return {busy, err, ff_en, ff_d, ack, gnt};
  endfunction

  function automatic logic [14:0] expv(logic b, logic e, logic en, logic [3:0] d,
                                       logic [3:0] a, logic [3:0] g);
    return {b, e, en, d, a, g};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_win(logic [3:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int t, cnt, n, s, w, m_ptr;
    logic [3:0] md, last_d, eg, ea;
    logic       een, eb;
    int exp_i[5];

    force_q0 = 1'b0;
    reset    = 1'b0;
    req      = '0;
    wdata    = '0;

    //        rst  req      wdata     gnt      ack      en  d     busy
    tbl[0]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{1'b1, 4'b0100, 16'h0600, 4'b0100, 4'b0000, 1'b1, 4'h6, 1'b1};
    tbl[4]  = '{1'b1, 4'b0100, 16'h0600, 4'b0100, 4'b0000, 1'b0, 4'h6, 1'b1};
    tbl[5]  = '{1'b1, 4'b0100, 16'h0600, 4'b0000, 4'b0100, 1'b0, 4'h6, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 16'h0600, 4'b0000, 4'b0000, 1'b0, 4'h6, 1'b0};
    tbl[7]  = '{1'b1, 4'b0011, 16'h00A5, 4'b0001, 4'b0000, 1'b1, 4'h5, 1'b1};
    tbl[8]  = '{1'b1, 4'b0011, 16'h00A5, 4'b0001, 4'b0000, 1'b0, 4'h5, 1'b1};
    tbl[9]  = '{1'b1, 4'b0011, 16'h00A5, 4'b0000, 4'b0001, 1'b0, 4'h5, 1'b0};
    tbl[10] = '{1'b1, 4'b0011, 16'h00A5, 4'b0010, 4'b0000, 1'b1, 4'hA, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 16'h00A5, 4'b0010, 4'b0000, 1'b0, 4'hA, 1'b1};
    tbl[12] = '{1'b1, 4'b0000, 16'h00A5, 4'b0000, 4'b0010, 1'b0, 4'hA, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 16'h00A5, 4'b0000, 4'b0000, 1'b0, 4'hA, 1'b0};

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].req;
      wdata = tbl[i].wd;
      @(negedge clk);
      chk($sformatf("tbl%0d", i), 32'(obs()),
          32'(expv(tbl[i].busy, 1'b0, tbl[i].en, tbl[i].d, tbl[i].ack, tbl[i].gnt)));
    end

    // All requesting: strict rotation, one ack every 3 cycles.
    do_reset();
    exp_i = '{0, 1, 2, 3, 0};
    wdata = 16'h8421;
    req   = 4'b1111;
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        if (n < 5) begin
          chk($sformatf("rr_order%0d", n), 32'(ack), 32'(4'b0001 << exp_i[n]));
          chk($sformatf("rr_cycle%0d", n), c, 3 + 3 * n);
          chk($sformatf("rr_bank%0d", n), 32'(ff_q), 32'(4'b0001 << exp_i[n]));
        end
        n++;
      end
    end
    chk("rr_count", n, 5);

    // Request dropped after grant still completes and advances the pointer.
    do_reset();
    wdata = 16'h00C0;
    req   = 4'b0010;
    t = 0;
    while (gnt != 4'b0010 && t < 4) begin @(negedge clk); t++; end
    chk("drop_gnt", 32'(gnt), 32'(4'b0010));
    req = 4'b0000;
    t = 0;
    while (ack == 0 && t < 4) begin @(negedge clk); t++; end
    chk("drop_ack", 32'(ack), 32'(4'b0010));
    chk("drop_lat", t, 2);
    chk("drop_bank", 32'(ff_q), 32'(4'hC));
    req   = 4'b1111;
    wdata = 16'h4321;
    @(negedge clk);
    chk("drop_ptr", 32'(gnt), 32'(4'b0100));
    req = '0;
    repeat (3) @(negedge clk);

    // Reset during WRITE clears outputs at once and restores requester-0 priority.
    do_reset();
    req   = 4'b0001;
    wdata = 16'h0007;
    t = 0;
    while (ack == 0 && t < 6) begin @(negedge clk); t++; end
    chk("rst_pre_ack", 32'(ack), 32'(4'b0001));
    req   = 4'b1001;
    wdata = 16'h9007;
    @(negedge clk);
    chk("rst_gnt3", 32'(gnt), 32'(4'b1000));
    #2 reset = 1'b0;
    #1 chk("rst_async", 32'(obs()), 32'd0);
    @(negedge clk);
    chk("rst_hold", 32'(obs()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_win0", 32'(gnt), 32'(4'b0001));
    req = '0;
    repeat (3) @(negedge clk);

`ifdef FFD_ARB_READBACK_CHECK_EN
    // Stuck readback: initial write plus two rewrites, then ack with err.
    do_reset();
    force_q0 = 1'b1;
    req      = 4'b0100;
    wdata    = 16'h0600;
    t = 0;
    cnt = 0;
    while (ack == 0 && t < 20) begin
      @(negedge clk);
      t++;
      if (ff_en) cnt++;
    end
    chk("retry_en_pulses", cnt, 3);
    chk("retry_ack", 32'(ack), 32'(4'b0100));
    chk("retry_err", 32'(err), 32'd1);
    chk("retry_lat", t, 7);
    force_q0 = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
`endif

    // Randomized traffic against a transaction timeline: a grant at edge s
    // shows gnt/en after s, CHECK after s+1, ack after s+2; next grant at s+3.
    do_reset();
    s = -1000;
    w = 0;
    m_ptr = 0;
    md = '0;
    last_d = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            wdata[i*W +: W] = 4'($urandom);
          end
        end else if (ack[i]) begin
          req[i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (k >= s + 3 && req != 0) begin
        s  = k;
        w  = rr_win(req, m_ptr);
        md = wdata[w*W +: W];
      end
      @(negedge clk);
      eg = '0; ea = '0; een = 1'b0; eb = 1'b0;
      if (k == s) begin
        eg = 4'b0001 << w; een = 1'b1; eb = 1'b1; last_d = md;
      end else if (k == s + 1) begin
        eg = 4'b0001 << w; eb = 1'b1;
      end else if (k == s + 2) begin
        ea = 4'b0001 << w;
        m_ptr = (w + 1) % N;
      end
      chk($sformatf("rand%0d", k), 32'(obs()), 32'(expv(eb, 1'b0, een, last_d, ea, eg)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
